// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined Urdhva-Tiryakbhyam multiplier with valid/ready flow control and a sideband tag.
// Define VEDIC_MUL_SIGNED_EN to add the sgn port for two's-complement operands.

module vedic_core #(
  parameter int W = 2
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);
  generate
    if (W == 2) begin : g_base
      // 2x2 base: vertical, crosswise, vertical
      logic c1;
      assign c1   = x[1] & y[0] & x[0] & y[1];
      assign p[0] = x[0] & y[0];
      assign p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
      assign p[2] = (x[1] & y[1]) ^ c1;
      assign p[3] = x[1] & y[1] & c1;
    end else begin : g_rec
      localparam int HW = W / 2;
      logic [W-1:0] hh, hl, lh, ll;
      logic [W:0]   mid;
      vedic_core #(.W(HW)) u_hh (.x(x[W-1:HW]), .y(y[W-1:HW]), .p(hh));
      vedic_core #(.W(HW)) u_hl (.x(x[W-1:HW]), .y(y[HW-1:0]), .p(hl));
      vedic_core #(.W(HW)) u_lh (.x(x[HW-1:0]), .y(y[W-1:HW]), .p(lh));
      vedic_core #(.W(HW)) u_ll (.x(x[HW-1:0]), .y(y[HW-1:0]), .p(ll));
      assign mid = {1'b0, hl} + {1'b0, lh};
      assign p   = {hh, ll} + ({{(W-1){1'b0}}, mid} << HW);
    end
  endgenerate
endmodule

module vedic_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef VEDIC_MUL_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] a_m, b_m;
  logic [WIDTH-1:0] pp_hh, pp_hl, pp_lh, pp_ll;

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_hh, s1_hl, s1_lh, s1_ll;
  logic [WIDTH-1:0] s2_hh, s2_ll;
  logic [WIDTH:0]   s2_mid;
  logic [TAG_W-1:0] s1_tag, s2_tag;

  logic [2*WIDTH-1:0] sum, prod;
  logic s3_open, s2_open, s1_open;

`ifdef VEDIC_MUL_SIGNED_EN
  logic sign_in, s1_neg, s2_neg;
  // Magnitude of the most negative value still fits the unsigned width.
  assign a_m     = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_m     = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign sign_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign a_m = a;
  assign b_m = b;
`endif

  vedic_core #(.W(H)) u_hh (.x(a_m[WIDTH-1:H]), .y(b_m[WIDTH-1:H]), .p(pp_hh));
  vedic_core #(.W(H)) u_hl (.x(a_m[WIDTH-1:H]), .y(b_m[H-1:0]),     .p(pp_hl));
  vedic_core #(.W(H)) u_lh (.x(a_m[H-1:0]),     .y(b_m[WIDTH-1:H]), .p(pp_lh));
  vedic_core #(.W(H)) u_ll (.x(a_m[H-1:0]),     .y(b_m[H-1:0]),     .p(pp_ll));

  assign sum = {s2_hh, s2_ll} + ({{(WIDTH-1){1'b0}}, s2_mid} << H);
`ifdef VEDIC_MUL_SIGNED_EN
  assign prod = s2_neg ? (~sum + 1'b1) : sum;
`else
  assign prod = sum;
`endif

  // A stage may load when it is empty or its content leaves this cycle.
  assign s3_open  = !out_valid || out_ready;
  assign s2_open  = !s2_valid || s3_open;
  assign s1_open  = !s1_valid || s2_open;
  assign in_ready = reset && s1_open;
  assign busy     = s1_valid | s2_valid | out_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_hh     <= '0;
      s1_hl     <= '0;
      s1_lh     <= '0;
      s1_ll     <= '0;
      s1_tag    <= '0;
      s2_hh     <= '0;
      s2_ll     <= '0;
      s2_mid    <= '0;
      s2_tag    <= '0;
      result    <= '0;
      out_tag   <= '0;
`ifdef VEDIC_MUL_SIGNED_EN
      s1_neg    <= 1'b0;
      s2_neg    <= 1'b0;
`endif
    end else begin
      if (s1_open) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_hh  <= pp_hh;
          s1_hl  <= pp_hl;
          s1_lh  <= pp_lh;
          s1_ll  <= pp_ll;
          s1_tag <= in_tag;
`ifdef VEDIC_MUL_SIGNED_EN
          s1_neg <= sign_in;
`endif
        end
      end
      if (s2_open) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_hh  <= s1_hh;
          s2_ll  <= s1_ll;
          s2_mid <= {1'b0, s1_hl} + {1'b0, s1_lh};
          s2_tag <= s1_tag;
`ifdef VEDIC_MUL_SIGNED_EN
          s2_neg <= s1_neg;
`endif
        end
      end
      if (s3_open) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          result  <= prod;
          out_tag <= s2_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Scoreboard bench for vedic_mul_pipe: 8-bit and 16-bit instances, expected products queued at accept
// and popped by per-instance monitors when a result transfers.

module tb_vedic_mul_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b1, sgn = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] result;
  logic [3:0]  out_tag;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b1, sgn16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  in_tag16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] result16;
  logic [3:0]  out_tag16;

  vedic_mul_pipe #(.WIDTH(8), .TAG_W(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag),
`ifdef VEDIC_MUL_SIGNED_EN
    .sgn(sgn),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .busy(busy)
  );

  vedic_mul_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .in_tag(in_tag16),
`ifdef VEDIC_MUL_SIGNED_EN
    .sgn(sgn16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .out_tag(out_tag16), .busy(busy16)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int checks = 0, errors = 0, cyc = 0, waits = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic [3:0] t,
                       input logic s, input logic [15:0] req, input bit lat);
    exp_t e;
    int n;
    @(negedge clk);
    a = x; b = y; in_tag = t; sgn = s; in_valid = 1'b1;
    #1;
    if (!in_ready) waits++;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) fail("accept_timeout8");
    e.res = {16'h0, req}; e.tag = t; e.cyc = cyc; e.lat = lat;
    q8.push_back(e);
  endtask

  task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic [3:0] t,
                        input logic [31:0] req);
    exp_t e;
    int n;
    @(negedge clk);
    a16 = x; b16 = y; in_tag16 = t; in_valid16 = 1'b1;
    #1;
    n = 0;
    while (!in_ready16 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready16) fail("accept_timeout16");
    e.res = req; e.tag = t; e.cyc = cyc; e.lat = 1'b1;
    q16.push_back(e);
  endtask

  task automatic idle8();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin : monitor8
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (reset && out_valid && out_ready) begin
        if (q8.size() == 0) fail("unexpected_out8");
        else begin
          e = q8.pop_front();
          chk("result8", {16'h0, result}, e.res);
          chk("tag8", {28'h0, out_tag}, {28'h0, e.tag});
          if (e.lat) chk("latency8", cyc - e.cyc, 32'd3);
        end
      end
    end
  end

  initial begin : monitor16
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (reset && out_valid16 && out_ready16) begin
        if (q16.size() == 0) fail("unexpected_out16");
        else begin
          e = q16.pop_front();
          chk("result16", result16, e.res);
          chk("tag16", {28'h0, out_tag16}, {28'h0, e.tag});
          if (e.lat) chk("latency16", cyc - e.cyc, 32'd3);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] xe, ye;
    int n;
    // Reset state, with in_valid asserted to show it is ignored.
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_result",    {16'h0, result},    32'd0);
    chk("rst_tag",       {28'h0, out_tag},   32'd0);
    chk("rst_busy",      {31'h0, busy},      32'd0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_out_valid", {31'h0, out_valid}, 32'd0);

    // Single op, full latency.
    send8(8'hFF, 8'hFF, 4'd5, 1'b0, 16'hFE01, 1'b1);
    idle8();
    repeat (5) @(negedge clk);

    // Directed back-to-back vectors.
    send8(8'h00, 8'h37, 4'd1, 1'b0, 16'h0000, 1'b1);
    send8(8'h01, 8'hAB, 4'd2, 1'b0, 16'h00AB, 1'b1);
    send8(8'h80, 8'h80, 4'd3, 1'b0, 16'h4000, 1'b1);
    send8(8'h0F, 8'hF0, 4'd4, 1'b0, 16'h0E10, 1'b1);
    send8(8'h12, 8'h34, 4'd6, 1'b0, 16'h03A8, 1'b1);
    idle8();
    repeat (5) @(negedge clk);

    // Streaming sweep, consumer always ready: no backpressure expected.
    waits = 0;
    for (int i = 0; i < 4096; i++) begin
      xe = 16'(i & 255);
      ye = 16'((i * 37 + 11) & 255);
      send8(xe[7:0], ye[7:0], 4'(i), 1'b0, xe * ye, 1'b1);
    end
    idle8();
    chk("sweep_no_backpressure", waits, 32'd0);
    repeat (6) @(negedge clk);

    // Stall: fill the pipe with the consumer blocked.
    out_ready = 1'b0;
    send8(8'h03, 8'h05, 4'd1, 1'b0, 16'h000F, 1'b0);
    send8(8'h10, 8'h10, 4'd2, 1'b0, 16'h0100, 1'b0);
    send8(8'hC8, 8'h02, 4'd3, 1'b0, 16'h0190, 1'b0);
    idle8();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", {31'h0, in_ready},  32'd0);
      chk("stall_valid",    {31'h0, out_valid}, 32'd1);
      chk("stall_result",   {16'h0, result},    32'h000F);
      chk("stall_tag",      {28'h0, out_tag},   32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall_drained", q8.size(), 32'd0);

    // Reset with two ops in flight: they must vanish.
    send8(8'h21, 8'h03, 4'd7, 1'b0, 16'h0063, 1'b0);
    send8(8'h22, 8'h04, 4'd8, 1'b0, 16'h0088, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("midrst_result",    {16'h0, result},    32'd0);
    chk("midrst_busy",      {31'h0, busy},      32'd0);
    q8.delete();
    q16.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send8(8'h07, 8'h09, 4'd9, 1'b0, 16'h003F, 1'b1);
    idle8();
    repeat (5) @(negedge clk);

    // 16-bit instance.
    send16(16'hFFFF, 16'hFFFF, 4'd1, 32'hFFFE0001);
    send16(16'h8000, 16'h0002, 4'd2, 32'h00010000);
    send16(16'h1234, 16'h0010, 4'd3, 32'h00012340);
    @(negedge clk);
    in_valid16 = 1'b0;

`ifdef VEDIC_MUL_SIGNED_EN
    send8(8'hFF, 8'h02, 4'd1, 1'b1, 16'hFFFE, 1'b1);
    send8(8'h80, 8'h80, 4'd2, 1'b1, 16'h4000, 1'b1);
    send8(8'h80, 8'h7F, 4'd3, 1'b1, 16'hC080, 1'b1);
    send8(8'hFF, 8'h02, 4'd4, 1'b0, 16'h01FE, 1'b1);
    idle8();
`endif

    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 50) begin
      @(negedge clk); n++;
    end
    if (q8.size() != 0 || q16.size() != 0) fail("final_drain");
    #1;
    chk("final_busy8",  {31'h0, busy},   32'd0);
    chk("final_busy16", {31'h0, busy16}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
